// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, stalling on mem_ready and flagging unsupported opcodes.
module multicycle_controller (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t     state_q, state_d, cur;
  logic [1:0] alu_op;
  logic       pcw_raw, mw_raw, irw_raw, rw_raw, ill_raw;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // While in reset the outputs decode as FETCH so a pending store strobe drops immediately.
  assign cur   = resetn ? state_q : S_FETCH;
  assign state = cur;

  always_comb begin
    state_d    = S_FETCH;
    pcw_raw    = 1'b0;
    mw_raw     = 1'b0;
    irw_raw    = 1'b0;
    rw_raw     = 1'b0;
    ill_raw    = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (cur)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw_raw    = mem_ready;
        pcw_raw    = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRNCH:          state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            ill_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        rw_raw     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mw_raw  = 1'b1;
        state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: rw_raw = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        case (funct3)
          3'b000:  pcw_raw = zero;
          3'b001:  pcw_raw = ~zero;
          default: pcw_raw = 1'b0;
        endcase
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw_raw   = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_write      = resetn & pcw_raw;
  assign mem_write     = resetn & mw_raw;
  assign ir_write      = resetn & irw_raw;
  assign reg_write     = resetn & rw_raw;
  assign illegal_instr = resetn & ill_raw;

  // Only register-register ops honour instr[30] as sub; addi with bit 30 set still adds.
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: imm_src = 2'b01;
      OP_BRNCH: imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized + directed bench: each instruction is expanded into an expected per-cycle trace
// from its instruction class and stall counts, then compared cycle by cycle against the controller.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  multicycle_controller dut (
    .clk(clk), .resetn(resetn), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw, ill, mr;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e;
    e.st = st; e.pcw = 0; e.adr = 0; e.mw = 0; e.irw = 0; e.rw = 0; e.ill = 0;
    e.rs = 0; e.sa = 0; e.sb = 0; e.ac = 0;
    e.mr = 1'($urandom_range(0, 1));
    return e;
  endfunction

  // Operation the ALU must perform for an arithmetic instruction.
  function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic is_sub);
    case (f3)
      3'd0:    return is_sub ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_exp(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
  endfunction

  task automatic push_wb();
    exp_t e;
    e = blank(8); e.rw = 1; exp_q.push_back(e);
  endtask

  // Expected trace of one instruction: fs FETCH stalls, ms memory stalls.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int fs, input int ms);
    exp_t e;
    for (int i = 0; i <= fs; i++) begin
      e = blank(0); e.rs = 2'b10; e.sb = 2'b10;
      e.mr = (i == fs); e.pcw = e.mr; e.irw = e.mr;
      exp_q.push_back(e);
    end
    e = blank(1); e.sa = 1; e.sb = 1; e.ill = !legal(o); exp_q.push_back(e);
    case (o)
      7'b0000011, 7'b0100011: begin
        e = blank(2); e.sa = 2; e.sb = 1; exp_q.push_back(e);
        for (int i = 0; i <= ms; i++) begin
          e = blank(o[5] ? 4'd5 : 4'd3); e.adr = 1; e.mw = o[5]; e.mr = (i == ms);
          exp_q.push_back(e);
        end
        if (!o[5]) begin
          e = blank(4); e.rs = 1; e.rw = 1; exp_q.push_back(e);
        end
      end
      7'b0110011: begin
        e = blank(6); e.sa = 2; e.ac = alu_exp(f3, f7); exp_q.push_back(e);
        push_wb();
      end
      7'b0010011: begin
        e = blank(7); e.sa = 2; e.sb = 1; e.ac = alu_exp(f3, 1'b0); exp_q.push_back(e);
        push_wb();
      end
      7'b1100011: begin
        e = blank(9); e.sa = 2; e.ac = 3'b001;
        e.pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
        exp_q.push_back(e);
      end
      7'b1101111: begin
        e = blank(10); e.sa = 1; e.sb = 2; e.pcw = 1; exp_q.push_back(e);
        push_wb();
      end
      default: ;
    endcase
  endtask

  // Consume n trace entries (all if n<0); entered and left just after a rising edge.
  task automatic run_n(input int n);
    exp_t e;
    int k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      e = exp_q.pop_front();
      mem_ready = e.mr;
      @(negedge clk);
      chk("state", state, e.st);
      chk("pc_write", 4'(pc_write), 4'(e.pcw));
      chk("adr_src", 4'(adr_src), 4'(e.adr));
      chk("mem_write", 4'(mem_write), 4'(e.mw));
      chk("ir_write", 4'(ir_write), 4'(e.irw));
      chk("reg_write", 4'(reg_write), 4'(e.rw));
      chk("illegal_instr", 4'(illegal_instr), 4'(e.ill));
      chk("result_src", 4'(result_src), 4'(e.rs));
      chk("alu_src_a", 4'(alu_src_a), 4'(e.sa));
      chk("alu_src_b", 4'(alu_src_b), 4'(e.sb));
      chk("alu_control", 4'(alu_control), 4'(e.ac));
      chk("imm_src", 4'(imm_src), 4'(imm_exp(op)));
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int fs, input int ms);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build(o, f3, f7, z, fs, ms);
    run_n(-1);
  endtask

  logic [6:0] kinds[7];

  initial begin
    kinds = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0};
    resetn = 0; mem_ready = 1; op = 7'b0110011; funct3 = 0; funct7b5 = 0; zero = 0;

    // Reset: enables forced low even with mem_ready high, selects show FETCH.
    @(negedge clk);
    chk("rst_state", state, 4'd0);
    chk("rst_ir_write", 4'(ir_write), 4'd0);
    chk("rst_pc_write", 4'(pc_write), 4'd0);
    chk("rst_reg_write", 4'(reg_write), 4'd0);
    chk("rst_mem_write", 4'(mem_write), 4'd0);
    chk("rst_alu_src_b", 4'(alu_src_b), 4'd2);
    chk("rst_result_src", 4'(result_src), 4'd2);
    @(posedge clk); #1;
    resetn = 1;

    // Directed sequence.
    instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);   // add
    instr(7'b0000011, 3'd2, 1'b0, 1'b0, 2, 3);   // lw with stalls, 10 cycles
    instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 0);   // sw
    instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);   // beq taken
    instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);   // bne not taken
    instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);   // sub
    instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);   // addi, instr[30]=1
    instr(7'b0010011, 3'd2, 1'b0, 1'b0, 0, 0);   // slti
    instr(7'b0010011, 3'd6, 1'b0, 1'b0, 0, 0);   // ori
    instr(7'b0010011, 3'd7, 1'b0, 1'b0, 0, 0);   // andi
    instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);   // jal
    instr(7'b0000000, 3'd0, 1'b0, 1'b0, 0, 0);   // illegal

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] o;
      o = kinds[$urandom_range(0, 6)];
      if (o == 7'b0) begin
        o = 7'($urandom);
        while (legal(o)) o = 7'($urandom);
      end
      instr(o, 3'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset during a MEMWRITE wait aborts the store.
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 0; zero = 0;
    build(op, funct3, funct7b5, zero, 0, 4);
    run_n(3);
    mem_ready = 0;
    @(negedge clk);
    chk("mw_wait_state", state, 4'd5);
    chk("mw_wait_strobe", 4'(mem_write), 4'd1);
    resetn = 0;
    #1;
    chk("mw_rst_strobe", 4'(mem_write), 4'd0);
    @(posedge clk); #1;
    chk("mw_rst_state", state, 4'd0);
    chk("mw_rst_strobe2", 4'(mem_write), 4'd0);
    exp_q.delete();
    resetn = 1;
    instr(7'b0110011, 3'd7, 1'b0, 1'b0, 1, 0);   // recovers normally

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multi-cycle RV32I core. It sequences the shared datapath (one memory port, one ALU, the PC, IR and register-file write port) through fetch, decode, execute, memory and writeback steps. It drives every write enable and every select of the 3- and 4-input datapath muxes. It stalls on a memory ready handshake and flags illegal opcodes.

## Interface
Parameters:
- none; widths are fixed by the RV32I encoding.

Ports:
- clk  in  1  single clock, rising edge
- resetn  in  1  reset; **synchronous and active-low (one clock, synchronous active-low reset)**
- op  in  7  instr[6:0], taken from the IR
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, combinational, valid in the BEQ state
- mem_ready  in  1  memory has completed the access presented this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address mux: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rd1
- alu_src_b  out  2  ALU B mux: 00 = rd2, 01 = ImmExt, 10 = constant 4
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- reg_write  out  1  register-file write enable
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state encoding, for debug

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are unreachable and recover to FETCH.
- Outputs are Moore, decoded from state. The exceptions are pc_write, which also uses zero and mem_ready, and the mem_ready gating below. Unlisted selects are 00 and unlisted enables are 0.
- alu_op is an internal 2-bit signal: 00 selects add, 01 selects sub, 10 selects the funct decode.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=mem_ready and pc_write=mem_ready.
  - Go to DECODE if mem_ready, otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, which precomputes the branch target.
  - op 0000011 or 0100011 → MEMADR
  - op 0110011 → EXECUTER
  - op 0010011 → EXECUTEI
  - op 1100011 → BEQ
  - op 1101111 → JAL
  - any other op → FETCH, with illegal_instr=1 for this cycle.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Go to MEMWB when mem_ready, otherwise hold.
- MEMWB: result_src=01, reg_write=1. Go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held until mem_ready. Go to FETCH when mem_ready.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write=zero when funct3=000 (beq).
  - pc_write=!zero when funct3=001 (bne).
  - Other funct3 values give pc_write=0.
  - Go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB.
- ALU decode when alu_op=10:
  - funct3 000: sub if op[5]=1 and funct7b5=1, otherwise add. This makes addi with instr[30]=1 still add.
  - funct3 010 → slt, 110 → or, 111 → and.
  - Any other funct3 → add.
- imm_src is combinational from op in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - all others → 00

## Timing
- Reset: while resetn=0, state loads FETCH on every rising edge.
  - pc_write, ir_write, mem_write, reg_write and illegal_instr are forced to 0 combinationally.
  - The remaining outputs show FETCH values.
  - Reset asserted mid-instruction, including during a MEMWRITE wait, aborts it at the next edge with no further write strobes.
- Cycle counts with mem_ready held at 1:
  - R-type and I-ALU: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - jal: 4
  - illegal opcode: 2
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly 1 cycle. During the wait all outputs hold steady and no enable other than mem_write pulses.
- mem_ready is ignored in every other state.

## Test plan
- Reset, then mem_ready=1 with the IR fed add (op 0110011, funct3 000, funct7b5 0):
  - state sequence 0,1,6,8,0
  - alu_control=000 in EXECUTER
  - reg_write=1 only in ALUWB
  - ir_write=1 and pc_write=1 only in FETCH
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - 10 cycles total
  - adr_src=1 in MEMREAD
  - result_src=01 and reg_write=1 in MEMWB
- sw, then beq with zero=1, then bne with zero=1:
  - mem_write=1 in MEMWRITE only
  - pc_write=1 in BEQ for beq
  - pc_write=0 in BEQ for bne
- sub (funct7b5=1) → alu_control=001; addi with instr[30]=1 → 000; slti → 101; ori → 011; andi → 010.
- jal:
  - states 0,1,10,8
  - pc_write=1 in JAL
  - imm_src=11
  - the ALUWB cycle writes PC+4
- Opcode 0000000:
  - illegal_instr pulses 1 cycle in DECODE, then FETCH.
- Separately, resetn dropped during a MEMWRITE wait:
  - mem_write falls in the same cycle
  - state is 0 after the edge
